// File: rtl/fetch.sv
// Instruction fetch stage: issues one instruction-bus request at a time, buffers the
// returned word for decode, and drops a response that a redirect has made stale.
module fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic [1:0]  dbg_state_o
);

  // Valid/ready: a decode entry transfers on any rising edge where out_valid && out_ready;
  // the bus request is held stable while ireq_valid is high until iresp_data_ok pulses.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [63:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[63:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt;
          // The request to pc is still outstanding unless it completes right now.
          if (!iresp_data_ok) begin
            req_addr_d = pc_q;
            state_d    = S_DROP;
          end
        end else if (iresp_data_ok) begin
          buf_instr_d = iresp_data;
          buf_pc_d    = pc_q;
          pc_d        = pc_q + 64'd4;
          state_d     = S_FULL;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = redirect_tgt;
        if (iresp_data_ok) state_d = S_REQ;
      end
      S_FULL: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (out_ready) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign ireq_valid  = (state_q == S_REQ) || (state_q == S_DROP);
  assign ireq_addr   = (state_q == S_DROP) ? req_addr_q : pc_q;
  assign out_valid   = (state_q == S_FULL) && !redirect_valid;
  assign out_instr   = buf_instr_q;
  assign out_pc      = buf_pc_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ireq_valid  output  1  instruction-bus request valid.
REQ-005 ireq_addr  output  64  instruction-bus request address.
REQ-006 iresp_data_ok  input  1  one-cycle pulse: the request's data is on iresp_data.
REQ-007 iresp_data  input  32  returned instruction word.
REQ-008 redirect_valid  input  1  one-cycle pulse: discard in-flight fetch work and restart at redirect_pc.
REQ-009 redirect_pc  input  64  redirect target.
REQ-010 out_valid  output  1  out_instr/out_pc are valid for decode.
REQ-011 out_ready  input  1  decode accepts the entry this cycle.
REQ-012 out_instr  output  32  raw instruction to decode.
REQ-013 out_pc  output  64  address of out_instr.

Function
REQ-014 The block SHALL keep the registers pc (64), req_addr (64), buf_instr (32), buf_pc (64) and state ∈ {REQ, DROP, FULL}.
REQ-015 In REQ, the block SHALL drive ireq_valid=1 and ireq_addr=pc, holding both stable until iresp_data_ok.
REQ-016 In REQ, iresp_data_ok without redirect_valid SHALL set buf_instr<=iresp_data, buf_pc<=pc, pc<=pc+4 and state<=FULL.
REQ-017 pc+4 SHALL wrap modulo 2^64 (for example, 64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-018 In REQ, redirect_valid without iresp_data_ok SHALL set req_addr<=pc, pc<=redirect_pc and state<=DROP.
REQ-019 In REQ, redirect_valid together with iresp_data_ok SHALL discard the data, set pc<=redirect_pc and keep state=REQ.
REQ-020 In DROP, the block SHALL drive ireq_valid=1 with ireq_addr=req_addr, keeping the stale request stable until it completes.
REQ-021 In DROP, iresp_data_ok SHALL discard the data and set state<=REQ.
REQ-022 In DROP, redirect_valid SHALL overwrite pc<=redirect_pc whether or not iresp_data_ok is also high; the state transition follows REQ-021 as normal.
REQ-023 In FULL, the block SHALL drive ireq_valid=0, out_instr=buf_instr and out_pc=buf_pc.
REQ-024 out_valid SHALL equal (state==FULL) && !redirect_valid, which is combinational.
REQ-025 In FULL, out_valid && out_ready SHALL set state<=REQ; the next fetch request is issued the following cycle.
REQ-026 In FULL, redirect_valid SHALL discard the buffered entry, set pc<=redirect_pc and state<=REQ, and out_ready is ignored that cycle.
REQ-027 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into pc.
REQ-028 Outside FULL, out_valid SHALL be 0; out_instr/out_pc SHALL still show the buffer registers.
REQ-029 Latency: request issue to out_valid is 1 cycle after iresp_data_ok; peak throughput is one instruction per 2 cycles with zero-wait memory.
REQ-030 iresp_data_ok while ireq_valid=0 (in FULL) SHALL be ignored.

Reset
REQ-031 While reset=1 at an edge, the block SHALL set pc<=RESET_PC, req_addr<=RESET_PC, buf_instr<=0, buf_pc<=0 and state<=REQ.
REQ-032 In the first cycle after reset deassertion, outputs SHALL be ireq_valid=1, ireq_addr=RESET_PC and out_valid=0.
REQ-033 Reset mid-operation (any state) SHALL abandon outstanding responses without a DROP phase, because the bus is reset together with the block.

Verification
REQ-034 Reset, then respond data_ok with 32'h0000_0013 one cycle later, out_ready=1 -> out_valid=1, out_pc=8000_0000, out_instr=0000_0013; the next ireq_addr is 8000_0004.
REQ-035 Hold out_ready=0 for 5 cycles in FULL -> out_valid stays 1 with stable outputs and ireq_valid=0; the entry is delivered once when out_ready=1.
REQ-036 In REQ at pc=8000_0008, pulse redirect to 8000_0100, then data_ok 3 cycles later -> ireq_addr stays 8000_0008 until data_ok, that data is never output, then ireq_addr=8000_0100.
REQ-037 redirect_valid with data_ok in the same cycle (target 8000_0203) -> no out_valid; the next ireq_addr is 8000_0200.
REQ-038 In FULL, redirect with out_ready=1 -> out_valid=0 that cycle; the next ireq_addr is the redirect target.
REQ-039 Redirect to FFFF_FFFF_FFFF_FFFC and complete one fetch -> out_pc=FFFF_FFFF_FFFF_FFFC; the next ireq_addr is 0.
